pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clk frequency in Hz; legal range 256 to 2^27.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level; 1 = generate pulses, 0 = stop and clear.
REQ-005 mode  input  2  rate select: 00 walk 32/s, 01 jog 64/s, 10 run 128/s, 11 hybrid.
REQ-006 pulse  output  1  one-cycle step pulse, the stimulus for the step-counting display FSM.
REQ-007 sec_tick  output  1  one-cycle strobe on the last cycle of each generated second.
REQ-008 active  output  1  high while in RUN.

Function
REQ-009 FSM states IDLE and RUN; IDLE->RUN when start=1; RUN->IDLE when start=0; both transitions take effect at the next edge.
REQ-010 Cycle numbering: the first cycle with active=1 is cycle 1 of second 1; each second spans exactly CLK_HZ cycles.
REQ-011 Rate generation by phase accumulator: each RUN cycle acc += rate; if result >= CLK_HZ, pulse=1 that cycle and acc -= CLK_HZ; otherwise pulse=0.
REQ-012 Accumulator width is clog2(CLK_HZ+128); no overflow for any legal rate.
REQ-013 Accumulator is cleared to 0 at every second boundary, so exactly `rate` pulses occur per second, the last in cycle CLK_HZ.
REQ-014 sec_tick=1 in cycle CLK_HZ of each second; sec_tick and the final pulse coincide.
REQ-015 mode is latched on IDLE->RUN and on each sec_tick; a mode change mid-second takes effect at the next second boundary.
REQ-016 Hybrid rate table, indexed 0..7: 20, 33, 66, 27, 70, 30, 19, 30.
REQ-017 Hybrid index is 0 on RUN entry, increments on each sec_tick, and wraps 7->0.
REQ-018 pulse is never high for two consecutive cycles.
REQ-019 In IDLE, pulse=0, sec_tick=0 and active=0; the accumulator, second counter and hybrid index are all held at 0.
REQ-020 start dropping mid-second aborts the second; no sec_tick is produced; the next start begins a fresh second 1.

Reset
REQ-021 When reset=1 at an edge, the FSM enters IDLE and all counters, the accumulator, the latched mode and the hybrid index clear to 0.
REQ-022 All outputs read 0 in the cycle after reset; reset overrides start.
REQ-023 Reset asserted mid-RUN is handled identically to REQ-021, with no partial pulse emitted.

Configuration
REQ-024 Macro PULSE_GEN_HYBRID_EN: when defined, mode 11 behaves per REQ-016/017.
REQ-025 When PULSE_GEN_HYBRID_EN is undefined:
- the hybrid table and index logic are absent;
- mode 11 has rate 0, so no pulses are produced;
- sec_tick and active still operate normally.

Structure
REQ-026 Package pulse_gen_pkg holds:
- the mode encoding enum;
- the rate constants WALK_RATE=32, JOG_RATE=64, RUN_RATE=128;
- the hybrid table constant;
- the FSM state typedef.
REQ-027 One sub-module, rate_accum, contains the accumulator and compare/subtract; its ports are clk, reset, clr, en, rate, and tick.

Verification (CLK_HZ=1024 for all benches)
REQ-028 Walk: reset, then start=1 with mode=00 for 2048 cycles -> 64 pulses total; first pulse in cycle 32; sec_tick in cycles 1024 and 2048.
REQ-029 Run with mode switch: start in mode=10, change mode to 01 at cycle 500 -> 128 pulses in second 1 and 64 pulses in second 2.
REQ-030 Hybrid (macro defined): 9 s with mode=11 -> per-second pulse counts 20, 33, 66, 27, 70, 30, 19, 30, 20.
REQ-031 Abort: start=1 in mode=00, drop start at cycle 600 (18 pulses seen), restart -> no sec_tick before restart; next sec_tick is 1024 cycles after active rises.
REQ-032 Reset: assert reset at cycle 700 of a jog second -> all outputs 0 the next cycle; with start held at 1, the first pulse comes 16 cycles after active re-asserts.
REQ-033 Macro undefined: mode=11 for 2048 cycles -> 0 pulses and 2 sec_ticks; throughout all benches, no two consecutive pulse cycles are observed.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and rate constants for the step pulse generator.
// Hybrid rate table exists only when PULSE_GEN_HYBRID_EN is defined.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'b00,
        MODE_JOG    = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_HYBRID = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] WALK_RATE = 8'd32;
    localparam logic [7:0] JOG_RATE  = 8'd64;
    localparam logic [7:0] RUN_RATE  = 8'd128;

`ifdef PULSE_GEN_HYBRID_EN
    // Element 0 is the rightmost entry: 20, 33, 66, 27, 70, 30, 19, 30.
    localparam logic [7:0][7:0] HYBRID_TABLE =
        {8'd30, 8'd19, 8'd30, 8'd70, 8'd27, 8'd66, 8'd33, 8'd20};
`endif

    // Fixed-rate modes only; hybrid is resolved by the caller.
    function automatic logic [7:0] base_rate(input mode_e m);
        logic [7:0] r;
        r = 8'd0;
        case (m)
            MODE_WALK: r = WALK_RATE;
            MODE_JOG:  r = JOG_RATE;
            MODE_RUN:  r = RUN_RATE;
            default:   r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pulse_gen_if.sv
// Control/status bundle between the pulse generator and its user.
interface pulse_gen_if;
    import pulse_gen_pkg::*;

    logic  start;
    mode_e mode;
    logic  pulse;
    logic  sec_tick;
    logic  active;

    modport master (output start, mode, input pulse, sec_tick, active);
    modport slave  (input start, mode, output pulse, sec_tick, active);
endinterface

// File: rtl/rate_accum.sv
// Phase accumulator: emits `rate` ticks per CLK_HZ enabled cycles.
module rate_accum #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] rate,
    output logic       tick
);
    localparam int ACC_W = $clog2(CLK_HZ + 128);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum  = acc + ACC_W'(rate);
        tick = en && (sum >= ACC_W'(CLK_HZ));
    end

    always_ff @(posedge clk) begin
        if (reset || clr)
            acc <= '0;
        else if (en)
            acc <= tick ? sum - ACC_W'(CLK_HZ) : sum;
    end
endmodule

// File: rtl/pulse_gen.sv
// Step pulse generator: IDLE/RUN FSM, one-second framing and rate selection.
// Optional macro PULSE_GEN_HYBRID_EN enables the cycling hybrid rate table.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    pulse_gen_if.slave  bus
);
    localparam int SEC_W = $clog2(CLK_HZ);

    state_e           state, state_nxt;
    mode_e            mode_q;
    logic [SEC_W-1:0] sec_cnt;
    logic             active, run_next, enter, sec_tick, tick;
    logic [7:0]       rate;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)  state_nxt = RUN;
            RUN:     if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign active   = (state == RUN);
    assign run_next = (state_nxt == RUN);
    assign enter    = (state == IDLE) && bus.start;
    assign sec_tick = active && (sec_cnt == SEC_W'(CLK_HZ - 1));

    // Cleared on the way out of RUN so IDLE always sees zeroed state.
    always_ff @(posedge clk) begin
        if (reset || !active || !run_next || sec_tick)
            sec_cnt <= '0;
        else
            sec_cnt <= sec_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mode_q <= MODE_WALK;
        else if (enter || sec_tick)
            mode_q <= bus.mode;
    end

`ifdef PULSE_GEN_HYBRID_EN
    logic [2:0] hyb_idx;

    always_ff @(posedge clk) begin
        if (reset || !run_next)
            hyb_idx <= '0;
        else if (sec_tick)
            hyb_idx <= hyb_idx + 1'b1;
    end

    assign rate = (mode_q == MODE_HYBRID) ? HYBRID_TABLE[hyb_idx] : base_rate(mode_q);
`else
    assign rate = base_rate(mode_q);
`endif

    rate_accum #(.CLK_HZ(CLK_HZ)) u_accum (
        .clk   (clk),
        .reset (reset),
        .clr   (!run_next || sec_tick),
        .en    (active),
        .rate  (rate),
        .tick  (tick)
    );

    assign bus.pulse    = tick;
    assign bus.sec_tick = sec_tick;
    assign bus.active   = active;
endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen at CLK_HZ=1024.
module tb_pulse_gen;
    import pulse_gen_pkg::*;

    bit   clk = 1'b0;
    logic reset;
    pulse_gen_if bus();

    pulse_gen #(.CLK_HZ(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc, npulse, sec_p, first_pulse, tick_pulse;
    int consec = 0;
    bit prev_pulse = 1'b0;
    int tick_cyc[$];
    int sec_counts[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic clear_stats();
        cyc = 0; npulse = 0; sec_p = 0; first_pulse = 0; tick_pulse = 0;
        tick_cyc.delete();
        sec_counts.delete();
    endtask

    // One clock; cyc numbers active cycles starting at 1.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.active) cyc++;
            if (bus.pulse) begin
                npulse++;
                sec_p++;
                if (first_pulse == 0) first_pulse = cyc;
                if (prev_pulse) consec++;
            end
            prev_pulse = bus.pulse;
            if (bus.sec_tick) begin
                tick_cyc.push_back(cyc);
                sec_counts.push_back(sec_p);
                sec_p = 0;
                if (bus.pulse) tick_pulse++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b1;
        bus.mode  = MODE_WALK;
        clear_stats();

        // Reset holds everything low even with start high
        step(3);
        check("rst_active", int'(bus.active), 0);
        check("rst_pulse", int'(bus.pulse), 0);
        check("rst_tick", int'(bus.sec_tick), 0);

        // Walk: 2 seconds
        reset = 1'b0;
        clear_stats();
        step(2048);
        check("walk_pulses", npulse, 64);
        check("walk_first", first_pulse, 32);
        check("walk_nticks", tick_cyc.size(), 2);
        check("walk_tick0", qget(tick_cyc, 0), 1024);
        check("walk_tick1", qget(tick_cyc, 1), 2048);
        check("walk_tick_pulse", tick_pulse, 2);
        bus.start = 1'b0;
        step(2);
        check("stop_active", int'(bus.active), 0);

        // Run with mid-second switch to jog
        clear_stats();
        bus.mode  = MODE_RUN;
        bus.start = 1'b1;
        step(500);
        bus.mode = MODE_JOG;
        step(1548);
        check("sw_sec1", qget(sec_counts, 0), 128);
        check("sw_sec2", qget(sec_counts, 1), 64);
        bus.start = 1'b0;
        step(2);

        // Abort mid-second then restart
        clear_stats();
        bus.mode  = MODE_WALK;
        bus.start = 1'b1;
        step(600);
        check("abort_pulses", npulse, 18);
        bus.start = 1'b0;
        step(50);
        check("abort_nticks", tick_cyc.size(), 0);
        check("abort_idle", int'(bus.active), 0);
        clear_stats();
        bus.start = 1'b1;
        step(1024);
        check("restart_nticks", tick_cyc.size(), 1);
        check("restart_tick", qget(tick_cyc, 0), 1024);
        check("restart_pulses", npulse, 32);
        bus.start = 1'b0;
        step(2);

        // Reset at cycle 700 of a jog second
        clear_stats();
        bus.mode  = MODE_JOG;
        bus.start = 1'b1;
        step(700);
        check("jog700_pulses", npulse, 43);
        reset = 1'b1;
        step(1);
        check("midrst_active", int'(bus.active), 0);
        check("midrst_pulse", int'(bus.pulse), 0);
        check("midrst_tick", int'(bus.sec_tick), 0);
        reset = 1'b0;
        clear_stats();
        step(32);
        check("postrst_first", first_pulse, 16);
        check("postrst_pulses", npulse, 2);
        bus.start = 1'b0;
        step(2);

        // Mode 11
        clear_stats();
        bus.mode  = MODE_HYBRID;
        bus.start = 1'b1;
`ifdef PULSE_GEN_HYBRID_EN
        begin
            int exp_h[9] = '{20, 33, 66, 27, 70, 30, 19, 30, 20};
            step(9 * 1024);
            check("hyb_nticks", sec_counts.size(), 9);
            for (int i = 0; i < 9; i++)
                check($sformatf("hyb_sec%0d", i + 1), qget(sec_counts, i), exp_h[i]);
        end
`else
        step(2048);
        check("m11_pulses", npulse, 0);
        check("m11_nticks", tick_cyc.size(), 2);
        check("m11_active", int'(bus.active), 1);
`endif
        bus.start = 1'b0;
        step(2);

        check("no_consecutive", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
